imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory.
- Receives a byte stream (valid/ready) from a host link such as a UART receiver, assembles little-endian 32-bit instruction words, and writes them through the instruction memory's write port starting at the reset PC word.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.

Parameters:
- ADDR_W, 15, word-address width of the instruction memory write port.
- START_WADDR, 15'h2000, first word address written; equals reset PC 32768 >> 2.
- CNT_W, 16, width of the word-count header and of words_loaded.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- NRST  input  1  synchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse.
- mem_waddr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  instruction word to write.
- cpu_nrst  output  1  active-low reset to the CPU core, including the PC register.
- busy  output  1  a load is in progress.
- done  output  1  image loaded and verified; sticky.
- err  output  1  checksum mismatch; sticky.
- words_loaded  output  CNT_W  count of words written so far.

Behaviour:
- Reset is synchronous, active-low, sampled on the clk posedge. All outputs are 0 while NRST=0, except:
  - rx_ready=1 from the first cycle after reset.
  - mem_waddr=START_WADDR.
  - cpu_nrst=0.
- Byte acceptance: a byte is accepted on a posedge where rx_valid && rx_ready. No other byte is consumed. rx_data is ignored when rx_valid=0.
- Stream format, in order:
  - Word count N, 2 bytes, LSB first.
  - N*4 data bytes; each word is little-endian, so the first byte maps to [7:0].
  - 1 checksum byte = 8-bit sum (mod 256) of all data bytes; header bytes are excluded.
- States:
  - S_LEN: collect 2 header bytes. After the 2nd byte, go to S_DATA if N!=0, else go to S_SUM.
  - S_DATA: collect bytes. A 2-bit byte counter wraps 3->0. On the 4th byte of word k, the next cycle drives mem_we=1 with mem_waddr=START_WADDR+k (mod 2^ADDR_W) and mem_wdata=the assembled word. After word N-1 is accepted, go to S_SUM.
  - S_SUM: accept 1 byte. If it matches, go to S_DONE; otherwise go to S_ERR.
  - S_DONE: rx_ready=0, done=1, cpu_nrst=1, busy=0. Held until NRST.
  - S_ERR: rx_ready=0, err=1, cpu_nrst=0, busy=0. Held until NRST.
- rx_ready=1 in S_LEN, S_DATA and S_SUM. The loader never stalls. Back-to-back bytes on consecutive cycles are supported, so a write pulse may coincide with acceptance of the next byte, including the checksum byte.
- Write latency is 1 cycle after the accepting edge. mem_we is high for exactly one cycle per word. mem_waddr and mem_wdata are registered and hold their last values when mem_we=0.
- words_loaded increments in the same cycle mem_we is asserted.
- busy goes to 1 on the cycle after the first header byte is accepted. It stays 1 until S_DONE or S_ERR.
- done, err and cpu_nrst update on the cycle after the checksum byte is accepted. By that point the final mem_we has already occurred. done and err are never both 1.
- Address wrap: START_WADDR+k wraps modulo 2^ADDR_W. The loader does not flag an error on wrap.
- Reset mid-load returns to S_LEN with counters cleared and cpu_nrst=0. Words already written are not erased.
- Idle gaps (rx_valid=0) of any length between bytes are allowed in every state; there is no timeout.

Test Plan:
- Header 01 00, data 13 00 00 00, checksum 13 -> one mem_we at waddr 15'h2000, wdata 32'h00000013. Next cycle after the checksum: done=1, cpu_nrst=1, words_loaded=1.
- Header 03 00, 12 data bytes 00..0B back-to-back, checksum 42 -> writes:
  - 0x2000: 32'h03020100
  - 0x2001: 32'h07060504
  - 0x2002: 32'h0B0A0908
  Each write is a single-cycle pulse; then done=1.
- Same stream as the previous case but checksum 00 -> three writes still occur, then err=1, done=0, cpu_nrst=0, rx_ready=0. All stay stable for 100 cycles.
- Header 00 00, checksum 00 -> no mem_we, done=1. Header 00 00, checksum 01 -> err=1.
- Random rx_valid gaps of 0–7 cycles in the 3-word stream -> identical writes and done. No byte is lost or duplicated, and rx_ready is never low before S_DONE.
- Assert NRST=0 after 6 data bytes, then send a fresh 1-word image -> write lands at 0x2000, words_loaded=1, done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them from START_WADDR upward, and releases the CPU once the checksum matches.
module imem_loader #(
   parameter int unsigned          ADDR_W      = 15,
   parameter logic [ADDR_W-1:0]    START_WADDR = 15'h2000,
   parameter int unsigned          CNT_W       = 16
) (
   input  logic              clk,
   input  logic              NRST,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_nrst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  words_loaded
);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_SUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q;
   logic              hdr_cnt_q;
   logic [7:0]        len_lo_q;
   logic [CNT_W-1:0]  len_q;
   logic [1:0]        byte_cnt_q;
   logic [23:0]       word_q;
   logic [7:0]        sum_q;
   logic              rx_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_waddr_q;
   logic [31:0]       mem_wdata_q;
   logic              cpu_nrst_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [CNT_W-1:0]  words_loaded_q;

   logic              accept;
   logic [15:0]       len_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [CNT_W-1:0]  cnt_inc_d;
   logic [7:0]        sum_d;

   assign accept    = rx_valid && rx_ready_q;
   assign len_d     = {rx_data, len_lo_q};
   // words_loaded doubles as the index of the word being assembled
   assign wr_addr_d = START_WADDR + ADDR_W'(words_loaded_q);
   assign cnt_inc_d = words_loaded_q + CNT_W'(1);
   assign sum_d     = sum_q + rx_data;

   // NOTE: every register in this block uses <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!NRST) begin
         state_q        <= S_LEN;
         hdr_cnt_q      <= 1'b0;
         len_lo_q       <= 8'h00;
         len_q          <= '0;
         byte_cnt_q     <= 2'd0;
         word_q         <= 24'h0;
         sum_q          <= 8'h00;
         rx_ready_q     <= 1'b1;
         mem_we_q       <= 1'b0;
         mem_waddr_q    <= START_WADDR;
         mem_wdata_q    <= 32'h0;
         cpu_nrst_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (accept) begin
            unique case (state_q)
               S_LEN: begin
                  busy_q    <= 1'b1;
                  hdr_cnt_q <= 1'b1;
                  len_lo_q  <= rx_data;
                  if (hdr_cnt_q) begin
                     len_q   <= CNT_W'(len_d);
                     state_q <= (len_d != 16'h0) ? S_DATA : S_SUM;
                  end
               end
               S_DATA: begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  word_q     <= {rx_data, word_q[23:8]};
                  sum_q      <= sum_d;
                  if (byte_cnt_q == 2'd3) begin
                     mem_we_q       <= 1'b1;
                     mem_waddr_q    <= wr_addr_d;
                     mem_wdata_q    <= {rx_data, word_q};
                     words_loaded_q <= cnt_inc_d;
                     if (cnt_inc_d == len_q) begin
                        state_q <= S_SUM;
                     end
                  end
               end
               S_SUM: begin
                  rx_ready_q <= 1'b0;
                  busy_q     <= 1'b0;
                  if (rx_data == sum_q) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     cpu_nrst_q <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign rx_ready     = rx_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_waddr    = mem_waddr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_nrst     = cpu_nrst_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_loaded_q;

endmodule
